// File: rtl/psi_result_reader_pkg.sv
// Shared types and width helpers for the PSI result reader.
package psi_result_reader_pkg;

  // Reader state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Default array geometry.
  localparam int DEF_W = 2;
  localparam int DEF_K = 2;

  // Width of an index into a K-word array (at least one bit).
  function automatic int idx_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  // Width of a counter that must reach K.
  function automatic int cnt_width(input int k);
    return $clog2(k + 1);
  endfunction

  localparam int IDXW = idx_width(DEF_K);
  localparam int CNTW = cnt_width(DEF_K);

endpackage

// File: rtl/psi_result_reader_if.sv
// Capture request, result array and streaming handshake of the PSI result reader.
interface psi_result_reader_if #(
  parameter int W = 2,
  parameter int K = 2
);
  import psi_result_reader_pkg::*;

  logic                    load;
  logic [W*K-1:0]          in_array;
  logic                    busy;
  logic                    out_valid;
  logic                    out_ready;
  logic [W-1:0]            out_data;
  logic                    out_last;
  logic [cnt_width(K)-1:0] count;
  logic                    done;

  // Producer of the array and consumer of the stream.
  modport master (
    output load, in_array, out_ready,
    input  busy, out_valid, out_data, out_last, count, done
  );

  // The reader itself.
  modport slave (
    input  load, in_array, out_ready,
    output busy, out_valid, out_data, out_last, count, done
  );
endinterface

// File: rtl/psi_more_detect.sv
// Lookahead: does any later slot hold a nonzero value different from the current one?
module psi_more_detect
  import psi_result_reader_pkg::*;
#(
  parameter int W = 2,
  parameter int K = 2
) (
  input  logic [W*K-1:0]          arr,
  input  logic [idx_width(K)-1:0] idx,
  output logic                    more
);

  logic [W-1:0] cur;
  logic [K-1:0] hit;

  assign cur = W'(arr >> (int'(idx) * W));

  // One compare per slot; a slot counts only if it lies beyond idx.
  always_comb begin
    hit = {K{1'b0}};
    for (int j = 0; j < K; j++) begin
      hit[j] = (j > int'(idx)) &&
               (arr[j*W +: W] != {W{1'b0}}) &&
               (arr[j*W +: W] != cur);
    end
  end

  assign more = |hit;

endmodule

// File: rtl/psi_result_reader.sv
// Walks a captured ascending PSI result array and streams its distinct
// nonzero members over valid/ready, flagging the last one.
module psi_result_reader
  import psi_result_reader_pkg::*;
#(
  parameter int W = 2,
  parameter int K = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  psi_result_reader_if.slave        bus
);

  localparam int IW = idx_width(K);
  localparam int CW = cnt_width(K);

  state_t          state;
  logic [W*K-1:0]  arr;
  logic [IW-1:0]   idx;
  logic [W-1:0]    prev;
  logic [W-1:0]    cur;
  logic            more;
  logic            emitable;

  logic            busy;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            out_last;
  logic [CW-1:0]   count;
  logic            done;

  assign cur = W'(arr >> (int'(idx) * W));

  // Zero marks an empty slot; a repeat of the last sent member is a duplicate.
  assign emitable = (cur != {W{1'b0}}) &&
                    ((count == {CW{1'b0}}) || (cur != prev));

  psi_more_detect #(.W(W), .K(K)) u_more (
    .arr  (arr),
    .idx  (idx),
    .more (more)
  );

  // Reader FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      arr       <= {(W*K){1'b0}};
      idx       <= {IW{1'b0}};
      prev      <= {W{1'b0}};
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= {W{1'b0}};
      out_last  <= 1'b0;
      count     <= {CW{1'b0}};
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.load) begin
            arr   <= bus.in_array;
            count <= {CW{1'b0}};
            idx   <= {IW{1'b0}};
            prev  <= {W{1'b0}};
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (emitable) begin
            out_valid <= 1'b1;
            out_data  <= cur;
            out_last  <= ~more;
            state     <= EMIT;
          end else if (idx == IW'(K - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            count     <= count + CW'(1);
            prev      <= out_data;
            if (out_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + IW'(1);
              state <= SCAN;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          done      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_last  = out_last;
  assign bus.count     = count;
  assign bus.done      = done;

endmodule

// File: tb/tb_psi_result_reader.sv
// Scoreboard bench for psi_result_reader with W=4, K=4.
module tb_psi_result_reader;

  localparam int W = 4;
  localparam int K = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  psi_result_reader_if #(.W(W), .K(K)) bus ();

  psi_result_reader #(.W(W), .K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [W:0] exp_q[$];          // {last, data}
  bit         hold_active = 1'b0;
  logic [W-1:0] hold_data;
  logic         hold_last;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int data, input bit last);
    logic [W:0] e;
    e = {last, W'(data)};
    exp_q.push_back(e);
  endtask

  // Monitor: compares every transfer with the scoreboard and checks stall stability.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (hold_active) begin
          check("stall_valid", int'(bus.out_valid), 1);
          check("stall_data", int'(bus.out_data), int'(hold_data));
          check("stall_last", int'(bus.out_last), int'(hold_last));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL xfer_extra: got data %0d, expected no transfer", bus.out_data);
          end else begin
            logic [W:0] e;
            e = exp_q.pop_front();
            check("xfer_data", int'(bus.out_data), int'(e[W-1:0]));
            check("xfer_last", int'(bus.out_last), int'(e[W]));
          end
        end
        if (bus.done) begin
          done_cnt++;
          check("done_busy", int'(bus.busy), 0);
        end
        hold_active = bus.out_valid && !bus.out_ready;
        hold_data   = bus.out_data;
        hold_last   = bus.out_last;
      end
    end
  end

  task automatic do_load(input logic [W*K-1:0] a);
    @(posedge clk); #1;
    bus.load     = 1'b1;
    bus.in_array = a;
    @(posedge clk); #1;
    bus.load     = 1'b0;
    bus.in_array = {(W*K){1'b1}};
  endtask

  // Cycle numbers are counted from the load cycle (1 = first cycle after it).
  task automatic run_wait(input int budget, output int first_v, output int done_c);
    first_v = -1;
    done_c  = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (bus.out_valid && first_v < 0) first_v = c;
      if (bus.done) begin
        done_c = c;
        break;
      end
    end
    if (done_c < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected done", budget);
    end
  endtask

  task automatic wait_valid(input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got no out_valid within %0d cycles, expected out_valid", budget);
    end
  endtask

  task automatic check_after(input string tag, input int cnt);
    @(negedge clk);
    check({tag, "_count"}, int'(bus.count), cnt);
    check({tag, "_busy_after"}, int'(bus.busy), 0);
    check({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    int fv;
    int dc;
    rst           = 1'b1;
    bus.load      = 1'b0;
    bus.in_array  = {(W*K){1'b0}};
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_data", int'(bus.out_data), 0);
    check("rst_last", int'(bus.out_last), 0);
    check("rst_count", int'(bus.count), 0);
    check("rst_done", int'(bus.done), 0);
    rst = 1'b0;

    // {0,0,3,7}: 3 then 7(last)
    bus.out_ready = 1'b1;
    done_cnt = 0;
    push_exp(3, 1'b0);
    push_exp(7, 1'b1);
    do_load({4'd7, 4'd3, 4'd0, 4'd0});
    run_wait(40, fv, dc);
    check("s1_first_valid", fv, 4);
    check("s1_done_cycle", dc, 7);
    check_after("s1", 2);

    // All empty: no output, done at load+5
    done_cnt = 0;
    do_load({4'd0, 4'd0, 4'd0, 4'd0});
    run_wait(40, fv, dc);
    check("s2_first_valid", fv, -1);
    check("s2_done_cycle", dc, 5);
    check_after("s2", 0);

    // {0,5,5,9}: duplicate suppressed
    done_cnt = 0;
    push_exp(5, 1'b0);
    push_exp(9, 1'b1);
    do_load({4'd9, 4'd5, 4'd5, 4'd0});
    run_wait(40, fv, dc);
    check("s3_first_valid", fv, 3);
    check_after("s3", 2);

    // {1,2,3,4} with a 3-cycle stall on every member
    bus.out_ready = 1'b0;
    done_cnt = 0;
    push_exp(1, 1'b0);
    push_exp(2, 1'b0);
    push_exp(3, 1'b0);
    push_exp(4, 1'b1);
    do_load({4'd4, 4'd3, 4'd2, 4'd1});
    for (int m = 0; m < 4; m++) begin
      wait_valid(20);
      repeat (3) begin
        @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("s4_count", int'(bus.count), 4);
    check("s4_busy_after", int'(bus.busy), 0);
    check("s4_done_pulses", done_cnt, 1);

    // Load during EMIT is ignored
    done_cnt = 0;
    push_exp(3, 1'b0);
    push_exp(7, 1'b1);
    do_load({4'd7, 4'd3, 4'd0, 4'd0});
    wait_valid(20);
    do_load({4'd8, 4'd8, 4'd8, 4'd8});
    check("s5_busy_mid", int'(bus.busy), 1);
    bus.out_ready = 1'b1;
    run_wait(40, fv, dc);
    check_after("s5", 2);
    repeat (3) @(negedge clk);
    check("s5_idle_busy", int'(bus.busy), 0);
    check("s5_idle_valid", int'(bus.out_valid), 0);

    // Reset while member 3 is presented, then replay the first run
    bus.out_ready = 1'b0;
    do_load({4'd7, 4'd3, 4'd0, 4'd0});
    wait_valid(20);
    check("s6_pre_data", int'(bus.out_data), 3);
    rst = 1'b1;
    #1;
    check("s6_rst_valid", int'(bus.out_valid), 0);
    check("s6_rst_busy", int'(bus.busy), 0);
    check("s6_rst_count", int'(bus.count), 0);
    check("s6_rst_data", int'(bus.out_data), 0);
    #1;
    rst = 1'b0;
    hold_active = 1'b0;
    exp_q.delete();
    bus.out_ready = 1'b1;
    done_cnt = 0;
    push_exp(3, 1'b0);
    push_exp(7, 1'b1);
    do_load({4'd7, 4'd3, 4'd0, 4'd0});
    run_wait(40, fv, dc);
    check("s6_first_valid", fv, 4);
    check("s6_done_cycle", dc, 7);
    check_after("s6", 2);

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1);
  end

endmodule
